// File: rtl/icu_core.sv
// Industrial control unit core: DW-bit result register, 16-opcode map,
// local program counter and a hardware return stack for JMP/RTN.
module icu_core #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int STK_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [3:0]    i_op,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_d,
    output logic          o_wr,
    output logic [AW-1:0] o_pc,
    output logic [DW-1:0] o_rr,
    output logic          o_jmp,
    output logic          o_rtn,
    output logic          o_flgo,
    output logic          o_flgf,
    output logic          o_stk_ovf,
    output logic          o_stk_unf
);

    localparam int SPW = $clog2(STK_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
        OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
        OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
        OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
    } op_e;

    op_e           op;
    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [DW-1:0] rr_q, rr_d, w_d;
    logic          ien_q, ien_d, oen_q, oen_d, skp_q, skp_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [AW-1:0] stk_q [STK_DEPTH];
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty, push_en, exec;

    assign op   = op_e'(i_op);
    assign exec = ~skp_q;

    always_comb begin
        w_d       = ien_q ? i_d : '0;
        pc_inc    = pc_q + AW'(1);
        stk_full  = (sp_q == SPW'(STK_DEPTH));
        stk_empty = (sp_q == '0);
        stk_top   = '0;
        for (int i = 0; i < STK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) stk_top = stk_q[i];
        end

        pc_d    = pc_inc;
        rr_d    = rr_q;
        ien_d   = ien_q;
        oen_d   = oen_q;
        skp_d   = 1'b0;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        // A skipped cycle only advances pc and clears the skip flag.
        if (exec) begin
            unique case (op)
                OP_LD:   rr_d = w_d;
                OP_LDC:  rr_d = ~w_d;
                OP_AND:  rr_d = rr_q & w_d;
                OP_ANDC: rr_d = rr_q & ~w_d;
                OP_OR:   rr_d = rr_q | w_d;
                OP_ORC:  rr_d = rr_q | ~w_d;
                OP_XNOR: rr_d = ~(rr_q ^ w_d);
                OP_IEN:  ien_d = i_d[0];
                OP_OEN:  oen_d = i_d[0];
                OP_SKZ:  skp_d = (rr_q == '0);
                OP_JMP: begin
                    pc_d = i_addr;
                    if (stk_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                    end
                end
                OP_RTN: begin
                    if (stk_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d = stk_top;
                        sp_d = sp_q - SPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (op)
            OP_STO:  o_d = rr_q;
            OP_STOC: o_d = ~rr_q;
            default: o_d = '0;
        endcase
        o_wr   = (op == OP_STO || op == OP_STOC) && exec && oen_q;
        o_jmp  = exec && (op == OP_JMP);
        o_rtn  = exec && (op == OP_RTN);
        o_flgo = exec && (op == OP_NOPO);
        o_flgf = exec && (op == OP_NOPF);
    end

    assign o_pc      = pc_q;
    assign o_rr      = rr_q;
    assign o_stk_ovf = ovf_q;
    assign o_stk_unf = unf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q  <= '0;
            rr_q  <= '0;
            ien_q <= 1'b1;
            oen_q <= 1'b1;
            skp_q <= 1'b0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            rr_q  <= rr_d;
            ien_q <= ien_d;
            oen_q <= oen_d;
            skp_q <= skp_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents survive reset; only the pointer is cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_en) begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                if (sp_q == SPW'(i)) stk_q[i] <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_icu_core.sv
// Bench for icu_core: directed program fragments with literal expectations,
// then randomized instruction streams checked against a behavioural model.
module tb_icu_core;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int STK = 4;

    logic          i_clk, i_rst;
    logic [3:0]    i_op;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_d;
    logic [DW-1:0] o_d, o_rr;
    logic [AW-1:0] o_pc;
    logic          o_wr, o_jmp, o_rtn, o_flgo, o_flgf, o_stk_ovf, o_stk_unf;

    icu_core #(.DW(DW), .AW(AW), .STK_DEPTH(STK)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_addr(i_addr), .i_d(i_d),
        .o_d(o_d), .o_wr(o_wr), .o_pc(o_pc), .o_rr(o_rr), .o_jmp(o_jmp),
        .o_rtn(o_rtn), .o_flgo(o_flgo), .o_flgf(o_flgf),
        .o_stk_ovf(o_stk_ovf), .o_stk_unf(o_stk_unf)
    );

    // clock/reset block
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // behavioural model state
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_rr;
    logic          m_ien, m_oen, m_skp, m_ovf, m_unf;
    logic [AW-1:0] m_stk[$];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] last_d;
    logic          last_wr, last_jmp, last_rtn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_rr = '0; m_ien = 1'b1; m_oen = 1'b1; m_skp = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic [3:0] op, input logic [AW-1:0] addr,
                              input logic [DW-1:0] d);
        logic [AW-1:0] nxt;
        logic [DW-1:0] w;
        nxt = m_pc + 8'd1;
        w   = m_ien ? d : 8'h00;
        if (m_skp) begin
            m_skp = 1'b0;
        end else begin
            case (op)
                4'h1: m_rr = w;
                4'h2: m_rr = ~w;
                4'h3: m_rr = m_rr & w;
                4'h4: m_rr = m_rr & ~w;
                4'h5: m_rr = m_rr | w;
                4'h6: m_rr = m_rr | ~w;
                4'h7: m_rr = ~(m_rr ^ w);
                4'hA: m_ien = d[0];
                4'hB: m_oen = d[0];
                4'hC: begin
                    if (m_stk.size() < STK) m_stk.push_back(nxt);
                    else m_ovf = 1'b1;
                    nxt = addr;
                end
                4'hD: begin
                    if (m_stk.size() > 0) nxt = m_stk.pop_back();
                    else m_unf = 1'b1;
                end
                4'hE: m_skp = (m_rr == 8'h00);
                default: ;
            endcase
        end
        m_pc = nxt;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1; i_op = 4'h1; i_addr = '0; i_d = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    // driver: one instruction per cycle, outputs compared before the edge
    task automatic step(input logic [3:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] d);
        logic [DW-1:0] e_d;
        logic          live, is_st;
        @(negedge i_clk);
        i_op = op; i_addr = addr; i_d = d;
        #1;
        live  = !m_skp;
        is_st = (op == 4'h8) || (op == 4'h9);
        e_d   = (op == 4'h8) ? m_rr : (op == 4'h9) ? ~m_rr : 8'h00;
        chk("o_pc",  32'(o_pc),  32'(m_pc));
        chk("o_rr",  32'(o_rr),  32'(m_rr));
        chk("o_d",   32'(o_d),   32'(e_d));
        chk("o_wr",  32'(o_wr),  32'(is_st && live && m_oen));
        chk("o_jmp", 32'(o_jmp), 32'(live && op == 4'hC));
        chk("o_rtn", 32'(o_rtn), 32'(live && op == 4'hD));
        chk("o_flgo", 32'(o_flgo), 32'(live && op == 4'h0));
        chk("o_flgf", 32'(o_flgf), 32'(live && op == 4'hF));
        chk("o_stk_ovf", 32'(o_stk_ovf), 32'(m_ovf));
        chk("o_stk_unf", 32'(o_stk_unf), 32'(m_unf));
        last_d = o_d; last_wr = o_wr; last_jmp = o_jmp; last_rtn = o_rtn;
        @(posedge i_clk);
        model_step(op, addr, d);
        #1;
    endtask

    initial begin
        logic [AW-1:0] p, pe;
        i_rst = 1'b0; i_op = 4'h1; i_addr = '0; i_d = '0;
        model_reset();

        do_reset();
        chk("rst_pc", 32'(o_pc), 32'h0);
        chk("rst_rr", 32'(o_rr), 32'h0);
        chk("rst_d",  32'(o_d),  32'h0);
        chk("rst_strobes", 32'({o_wr, o_jmp, o_rtn, o_flgf, o_stk_ovf, o_stk_unf}), 32'h0);

        // LD A5, ORC 0F, STO
        step(4'h1, 8'h00, 8'hA5);
        step(4'h6, 8'h00, 8'h0F);
        step(4'h8, 8'h00, 8'h00);
        chk("lit_rr_f5", 32'(o_rr), 32'hF5);
        chk("lit_sto_d", 32'(last_d), 32'hF5);
        chk("lit_sto_wr", 32'(last_wr), 32'h1);
        chk("lit_pc3", 32'(o_pc), 32'h3);

        // input masking
        step(4'hA, 8'h00, 8'h00);
        step(4'h1, 8'h00, 8'hFF);
        chk("lit_ien_off", 32'(o_rr), 32'h00);
        step(4'hA, 8'h00, 8'h01);
        step(4'h1, 8'h00, 8'h3C);
        chk("lit_ien_on", 32'(o_rr), 32'h3C);

        // output disabled store
        step(4'hB, 8'h00, 8'h00);
        step(4'h9, 8'h00, 8'h00);
        chk("lit_stoc_d", 32'(last_d), 32'hC3);
        chk("lit_stoc_wr", 32'(last_wr), 32'h0);
        step(4'hB, 8'h00, 8'h01);

        // SKZ with rr=0 suppresses the JMP
        step(4'h1, 8'h00, 8'h00);
        p = o_pc;
        step(4'hE, 8'h00, 8'h00);
        step(4'hC, 8'h40, 8'h00);
        pe = p + 8'd2;
        chk("lit_skz_pc", 32'(o_pc), 32'(pe));
        chk("lit_skz_jmp", 32'(last_jmp), 32'h0);
        step(4'h1, 8'h00, 8'h01);
        step(4'hE, 8'h00, 8'h00);
        step(4'hC, 8'h40, 8'h00);
        chk("lit_jmp_pc", 32'(o_pc), 32'h40);
        chk("lit_jmp_str", 32'(last_jmp), 32'h1);

        // call/return and underflow
        do_reset();
        for (int i = 0; i < 5; i++) step(4'h0, 8'h00, 8'h00);
        step(4'hC, 8'h20, 8'h00);
        chk("lit_call_pc", 32'(o_pc), 32'h20);
        step(4'hD, 8'h00, 8'h00);
        chk("lit_ret_pc", 32'(o_pc), 32'h6);
        chk("lit_ret_str", 32'(last_rtn), 32'h1);
        step(4'hD, 8'h00, 8'h00);
        chk("lit_unf_pc", 32'(o_pc), 32'h7);
        chk("lit_unf", 32'(o_stk_unf), 32'h1);
        step(4'h0, 8'h00, 8'h00);
        chk("lit_unf_sticky", 32'(o_stk_unf), 32'h1);

        // nesting past the stack depth
        do_reset();
        step(4'hC, 8'h10, 8'h00);
        step(4'hC, 8'h20, 8'h00);
        step(4'hC, 8'h30, 8'h00);
        step(4'hC, 8'h40, 8'h00);
        step(4'hC, 8'h50, 8'h00);
        chk("lit_ovf_pc", 32'(o_pc), 32'h50);
        chk("lit_ovf", 32'(o_stk_ovf), 32'h1);
        step(4'hD, 8'h00, 8'h00); chk("lit_pop1", 32'(o_pc), 32'h31);
        step(4'hD, 8'h00, 8'h00); chk("lit_pop2", 32'(o_pc), 32'h21);
        step(4'hD, 8'h00, 8'h00); chk("lit_pop3", 32'(o_pc), 32'h11);
        step(4'hD, 8'h00, 8'h00); chk("lit_pop4", 32'(o_pc), 32'h01);
        do_reset();
        chk("lit_rst_flags", 32'({o_stk_ovf, o_stk_unf}), 32'h0);

        // pc and return address wrap
        step(4'hC, 8'hFF, 8'h00);
        step(4'hC, 8'h10, 8'h00);
        step(4'hD, 8'h00, 8'h00);
        chk("lit_wrap_ret", 32'(o_pc), 32'h00);
        step(4'hC, 8'hFF, 8'h00);
        step(4'h0, 8'h00, 8'h00);
        chk("lit_wrap_inc", 32'(o_pc), 32'h00);

        // randomized stream with occasional reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else step(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
